gmii_tx_framer: RTL



---
 rtl/gmii_tx_framer_if.sv | 11 +
 rtl/gmii_tx_framer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_framer_if.sv
// Byte-wide valid/ready/last stream that carries frame bytes (DA through payload)
// from the MAC client into the GMII transmit framer.
interface gmii_tx_framer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps client bytes with preamble/SFD, zero-pads short frames,
// appends the CRC-32 FCS and enforces the inter-packet gap, aborting on underrun/over-length.
module gmii_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int MAX_FRAME    = 1514,
  parameter int IPG_CYCLES   = 12
) (
  input  logic            gmii_tx_clk,
  input  logic            rst_n,
  gmii_tx_framer_if.slave s,
  output logic            gmii_tx_en,
  output logic            gmii_tx_er,
  output logic [7:0]      gmii_txd,
  output logic            busy,
  output logic            frame_done,
  output logic            frame_err
);

  // The byte counter must hold count+1 of the largest limit without wrapping.
  localparam int LIMIT  = (MAX_FRAME > MIN_FRAME) ? MAX_FRAME : MIN_FRAME;
  localparam int CNT_W  = $clog2(LIMIT + 2);
  localparam int PH_A   = (PREAMBLE_LEN > IPG_CYCLES) ? PREAMBLE_LEN : IPG_CYCLES;
  localparam int PH_MAX = (PH_A > 4) ? PH_A : 4;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_FRAME);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_FRAME);
  localparam logic [PH_W-1:0]  PRE_LAST = PH_W'(PREAMBLE_LEN - 1);
  localparam logic [PH_W-1:0]  IPG_LAST = PH_W'(IPG_CYCLES - 1);
  localparam logic [PH_W-1:0]  FCS_LAST = PH_W'(3);

  typedef enum logic [3:0] {
    IDLE,
    PREAMBLE,
    SFD,
    PAYLOAD,
    PAD,
    FCS,
    ABORT,
    DISCARD,
    IPG
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      crc;
  logic [31:0]      crc_next;
  logic             last_seen;
  logic             at_max;
  logic             ready;
  logic             take;
  logic             en_d;
  logic             er_d;
  logic [7:0]       txd_d;
  logic [7:0]       fcs_byte;
  logic             done_d;
  logic             err_d;

  // Reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte per clock.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign cnt_inc   = byte_cnt + CNT_W'(1);
  assign at_max    = (byte_cnt == MAX_CNT);
  assign crc_next  = crc32_byte(crc, txd_d);
  assign busy      = (state != IDLE);
  assign s.s_ready = ready;

  always_comb begin
    case (phase[1:0])
      2'd0:    fcs_byte = ~crc[7:0];
      2'd1:    fcs_byte = ~crc[15:8];
      2'd2:    fcs_byte = ~crc[23:16];
      default: fcs_byte = ~crc[31:24];
    endcase
  end

  always_comb begin
    state_d = state;
    en_d    = 1'b0;
    er_d    = 1'b0;
    txd_d   = 8'h00;
    ready   = 1'b0;
    take    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (s.s_valid) state_d = PREAMBLE;
      end
      PREAMBLE: begin
        en_d  = 1'b1;
        txd_d = 8'h55;
        if (phase == PRE_LAST) state_d = SFD;
      end
      SFD: begin
        en_d    = 1'b1;
        txd_d   = 8'hD5;
        state_d = PAYLOAD;
      end
      PAYLOAD: begin
        // A missing byte or a byte past the length limit both end the frame with tx_er.
        ready = !at_max;
        en_d  = 1'b1;
        if (ready && s.s_valid) begin
          take  = 1'b1;
          txd_d = s.s_data;
          if (s.s_last) state_d = (cnt_inc < MIN_CNT) ? PAD : FCS;
        end else begin
          er_d    = 1'b1;
          state_d = ABORT;
        end
      end
      PAD: begin
        en_d = 1'b1;
        take = 1'b1;
        if (cnt_inc >= MIN_CNT) state_d = FCS;
      end
      FCS: begin
        en_d  = 1'b1;
        txd_d = fcs_byte;
        if (phase == FCS_LAST) begin
          state_d = IPG;
          done_d  = 1'b1;
        end
      end
      ABORT: begin
        if (last_seen) begin
          state_d = IPG;
          err_d   = 1'b1;
        end else begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        ready = 1'b1;
        if (s.s_valid && s.s_last) begin
          state_d = IPG;
          err_d   = 1'b1;
        end
      end
      IPG: begin
        if (phase == IPG_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Phase restarts on every state change and only runs in the timed states.
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      state <= state_d;
      if (state_d != state)
        phase <= '0;
      else if (state == PREAMBLE || state == FCS || state == IPG)
        phase <= phase + PH_W'(1);
    end
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt  <= '0;
      crc       <= 32'hFFFFFFFF;
      last_seen <= 1'b0;
    end else if (state == SFD) begin
      byte_cnt  <= '0;
      crc       <= 32'hFFFFFFFF;
      last_seen <= 1'b0;
    end else if (take) begin
      byte_cnt <= cnt_inc;
      crc      <= crc_next;
      if (state == PAYLOAD && s.s_last) last_seen <= 1'b1;
    end
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      gmii_txd   <= 8'h00;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      gmii_tx_en <= en_d;
      gmii_tx_er <= er_d;
      gmii_txd   <= txd_d;
      frame_done <= done_d;
      frame_err  <= err_d;
    end
  end

endmodule
